// File: rtl/cgra_sram_streamer.sv
// rtl/cgra_sram_streamer.sv - burst streamer between a single-port SRAM and valid/ready word streams
// Reads land in a 2-entry FIFO so the one-cycle SRAM latency never drops a word under backpressure.
module cgra_sram_streamer #(
  parameter int NUM_WORDS  = 1024,
  parameter int DATA_WIDTH = 32,
  localparam int AddrWidth = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [AddrWidth-1:0]    base_addr_i,
  input  logic [AddrWidth:0]      len_i,
  output logic                    busy_o,
  output logic                    done_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [DATA_WIDTH-1:0]   in_data_i,
  input  logic [DATA_WIDTH/8-1:0] in_be_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [DATA_WIDTH-1:0]   out_data_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [AddrWidth-1:0]    mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [AddrWidth-1:0] AddrOne  = AddrWidth'(1);
  localparam logic [AddrWidth-1:0] AddrLast = AddrWidth'(NUM_WORDS - 1);
  localparam logic [AddrWidth:0]   CntOne   = (AddrWidth + 1)'(1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [AddrWidth-1:0]  r_addr;
  logic [AddrWidth:0]    r_len;
  logic [AddrWidth:0]    r_issued;
  logic [AddrWidth:0]    r_popped;
  logic                  r_pending;
  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_rd_ptr;
  logic                  r_wr_ptr;
  logic [1:0]            r_count;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_issue;
  logic                  w_wr_issue;
  logic                  w_issue;
  logic [2:0]            w_occ;
  logic [AddrWidth:0]    w_issued_inc;
  logic [AddrWidth:0]    w_popped_inc;
  logic [AddrWidth-1:0]  w_addr_nxt;

  // Occupancy counts words already buffered plus the one still in flight from the SRAM.
  always_comb begin
    w_pop        = (r_count != 2'd0) && out_ready_i;
    w_push       = r_pending;
    w_occ        = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
    w_rd_issue   = (r_state == ST_READ) && (r_issued < r_len) && (w_occ < 3'd2);
    w_wr_issue   = (r_state == ST_WRITE) && in_valid_i;
    w_issue      = w_rd_issue || w_wr_issue;
    w_issued_inc = r_issued + CntOne;
    w_popped_inc = r_popped + CntOne;
    w_addr_nxt   = (r_addr == AddrLast) ? '0 : r_addr + AddrOne;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i == '0)  w_state_nxt = ST_DONE;
          else if (mode_i)  w_state_nxt = ST_WRITE;
          else              w_state_nxt = ST_READ;
        end
      end
      ST_WRITE: if (w_wr_issue && (w_issued_inc == r_len)) w_state_nxt = ST_DONE;
      ST_READ:  if (w_pop && (w_popped_inc == r_len)) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state != ST_IDLE);
    done_o      = (r_state == ST_DONE);
    in_ready_o  = (r_state == ST_WRITE);
    out_valid_o = (r_count != 2'd0);
    out_data_o  = r_fifo[r_rd_ptr];
    mem_req_o   = w_issue;
    mem_we_o    = w_wr_issue;
    mem_addr_o  = r_addr;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (r_state == ST_WRITE) begin
      mem_wdata_o = in_data_i;
      mem_be_o    = in_be_i;
    end else if (r_state == ST_READ) begin
      mem_be_o    = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_issued  <= '0;
      r_popped  <= '0;
      r_pending <= 1'b0;
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
      r_rd_ptr  <= 1'b0;
      r_wr_ptr  <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_rd_issue;
      if ((r_state == ST_IDLE) && start_i) begin
        r_addr   <= base_addr_i;
        r_len    <= len_i;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= w_addr_nxt;
          r_issued <= w_issued_inc;
        end
        if (w_pop) r_popped <= w_popped_inc;
      end
      if (w_push) begin
        r_fifo[r_wr_ptr] <= mem_rdata_i;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_cgra_sram_streamer.sv
// tb/tb_cgra_sram_streamer.sv - randomized bench for cgra_sram_streamer against a burst-level reference model
// The SRAM is modelled here; expectations come from burst base/len arithmetic and a pop-order scoreboard.
module tb_cgra_sram_streamer;

  localparam int N  = 1024;
  localparam int AW = 10;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          mode_i;
  logic [AW-1:0] base_addr_i;
  logic [AW:0]   len_i;
  logic          busy_o;
  logic          done_o;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [31:0]   in_data_i;
  logic [3:0]    in_be_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [31:0]   out_data_o;
  logic          mem_req_o;
  logic          mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_rdata_i;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  cgra_sram_streamer #(.NUM_WORDS(N), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .mode_i(mode_i),
    .base_addr_i(base_addr_i), .len_i(len_i), .busy_o(busy_o), .done_o(done_o),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_be_i(in_be_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM with one-cycle read latency
  logic [31:0] mem [N];
  logic [31:0] r_rdata = '0;
  bit          mem_init = 1'b0;
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < N; i++) mem[i] = $urandom;
      mem_init = 1'b1;
    end
    if (mem_req_o === 1'b1 && mem_we_o === 1'b0) r_rdata <= mem[mem_addr_o];
    if (mem_req_o === 1'b1 && mem_we_o === 1'b1)
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
  end
  assign mem_rdata_i = r_rdata;

  // Burst-level reference: phase 0 idle, 1 read, 2 write, 3 done
  int          m_ph = 0;
  bit          m_live = 1'b0;
  int          m_base = 0, m_len = 0, m_issued = 0, m_popped = 0;
  bit          m_prev_stall = 1'b0;
  logic [31:0] m_prev_data = '0;
  int          wlog_a[$];
  logic [31:0] wlog_d[$];
  logic [31:0] rlog[$];

  always @(negedge clk_i) begin
    bit pop;
    if (m_live) begin
      chk("busy", busy_o, m_ph != 0);
      chk("done", done_o, m_ph == 3);
      chk("in_ready", in_ready_o, m_ph == 2);
      if (m_ph == 2) begin
        chk("wr_req", mem_req_o, in_valid_i);
        chk("wr_we", mem_we_o, in_valid_i);
        if (in_valid_i) begin
          chk("wr_addr", mem_addr_o, (m_base + m_issued) % N);
          chk("wr_data", mem_wdata_o, in_data_i);
          chk("wr_be", mem_be_o, in_be_i);
          wlog_a.push_back(int'(mem_addr_o));
          wlog_d.push_back(mem_wdata_o);
        end
      end else if (m_ph == 1) begin
        chk("rd_we", mem_we_o, 1'b0);
        if (mem_req_o) begin
          chk("rd_within_len", m_issued < m_len, 1'b1);
          chk("rd_addr", mem_addr_o, (m_base + m_issued) % N);
          chk("rd_be", mem_be_o, 4'hF);
        end
      end else begin
        chk("idle_req", mem_req_o, 1'b0);
        chk("idle_we", mem_we_o, 1'b0);
      end
      if (m_ph != 1) chk("idle_out_valid", out_valid_o, 1'b0);
      else begin
        if (m_prev_stall) begin
          chk("hold_valid", out_valid_o, 1'b1);
          chk("hold_data", out_data_o, m_prev_data);
        end
        if (out_valid_o && out_ready_i) begin
          chk("rd_data", out_data_o, mem[(m_base + m_popped) % N]);
          rlog.push_back(out_data_o);
        end
      end
    end
    m_prev_stall = 1'b0;
    if (!rst_ni) begin
      m_ph   = 0;
      m_live = 1'b1;
    end else begin
      case (m_ph)
        0: if (start_i) begin
          m_base = int'(base_addr_i);
          m_len  = int'(len_i);
          m_issued = 0;
          m_popped = 0;
          m_ph = (len_i == 0) ? 3 : (mode_i ? 2 : 1);
        end
        2: if (in_valid_i) begin
          m_issued++;
          if (m_issued == m_len) m_ph = 3;
        end
        1: begin
          pop = out_valid_o && out_ready_i;
          if (mem_req_o) m_issued++;
          if (pop) m_popped++;
          if (m_live) chk("buffered_le2", (m_issued - m_popped) <= 2, 1'b1);
          m_prev_stall = out_valid_o && !out_ready_i;
          m_prev_data  = out_data_o;
          if (pop && m_popped == m_len) m_ph = 3;
        end
        default: m_ph = 0;
      endcase
    end
  end

  logic [31:0] dir_data [8];

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_out_valid"}, out_valid_o, 0);
    chk({tag, "_in_ready"}, in_ready_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_out_data"}, out_data_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_be"}, mem_be_o, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst_ni = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("reset");
  endtask

  // vm: 1 valid held else random; rm: 1 ready held, 2 toggle, else random
  task automatic run_cmd(input logic md, input int base, input int len, input int vm,
                         input int rm, input bit dir, output int lat, output int nval);
    int beat;
    bit got;
    wlog_a.delete(); wlog_d.delete(); rlog.delete();
    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = md; base_addr_i = AW'(base); len_i = (AW + 1)'(len);
    in_valid_i = 1'b0; out_ready_i = (rm != 0);
    beat = 0; lat = 0; nval = 0; got = 1'b0;
    for (int cyc = 0; cyc < 20000 && !got; cyc++) begin
      @(posedge clk_i); #1;
      if (dir) start_i = 1'b0;
      else begin
        start_i     = (cyc % 3 == 1);
        mode_i      = 1'($urandom);
        base_addr_i = AW'($urandom);
        len_i       = (AW + 1)'($urandom_range(0, 50));
      end
      in_valid_i  = (vm == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      in_data_i   = dir ? dir_data[beat % 8] : $urandom;
      in_be_i     = dir ? 4'hF : 4'($urandom);
      out_ready_i = (rm == 1) ? 1'b1 : (rm == 2) ? (cyc % 2 == 0) : 1'($urandom);
      @(negedge clk_i);
      lat++;
      if (out_valid_o) nval++;
      if (in_valid_i && in_ready_o) beat++;
      if (done_o) got = 1'b1;
    end
    chk("cmd_timeout", got, 1'b1);
  endtask

  initial begin
    int lat, nv;
    logic [31:0] k_abc [3];
    logic [31:0] k_low [4];
    logic [31:0] k_wrap [4];
    int          k_wrap_a [4];
    k_abc    = '{32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'hCCCC_CCCC};
    k_low    = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004};
    k_wrap   = '{32'hE000_0000, 32'hE111_1111, 32'hE222_2222, 32'hE333_3333};
    k_wrap_a = '{1022, 1023, 0, 1};
    rst_ni = 1'b0; start_i = 1'b0; mode_i = 1'b0; base_addr_i = '0; len_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; in_be_i = '0; out_ready_i = 1'b0;
    do_reset();

    for (int i = 0; i < 3; i++) dir_data[i] = k_abc[i];
    run_cmd(1'b1, 5, 3, 1, 1, 1'b1, lat, nv);
    chk("w3_latency", lat, 4);
    chk("w3_count", wlog_a.size(), 3);
    for (int i = 0; i < 3 && i < wlog_a.size(); i++) begin
      chk("w3_addr", wlog_a[i], 5 + i);
      chk("w3_data", wlog_d[i], k_abc[i]);
    end

    for (int i = 0; i < 4; i++) dir_data[i] = k_low[i];
    run_cmd(1'b1, 0, 4, 1, 1, 1'b1, lat, nv);
    run_cmd(1'b0, 0, 4, 0, 1, 1'b1, lat, nv);
    chk("r4_latency", lat, 7);
    chk("r4_valid_cycles", nv, 4);
    chk("r4_count", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("r4_data", rlog[i], k_low[i]);

    run_cmd(1'b0, 5, 6, 0, 2, 1'b1, lat, nv);
    chk("bp_count", rlog.size(), 6);
    for (int i = 0; i < 3 && i < rlog.size(); i++) chk("bp_data", rlog[i], k_abc[i]);

    for (int i = 0; i < 4; i++) dir_data[i] = k_wrap[i];
    run_cmd(1'b1, 1022, 4, 1, 1, 1'b1, lat, nv);
    chk("wrap_count", wlog_a.size(), 4);
    for (int i = 0; i < 4 && i < wlog_a.size(); i++) chk("wrap_addr", wlog_a[i], k_wrap_a[i]);
    run_cmd(1'b0, 1022, 4, 0, 1, 1'b1, lat, nv);
    chk("wrap_rd_count", rlog.size(), 4);
    for (int i = 0; i < 4 && i < rlog.size(); i++) chk("wrap_rd_data", rlog[i], k_wrap[i]);

    run_cmd(1'b1, 300, 0, 1, 1, 1'b1, lat, nv);
    chk("len0_wr_latency", lat, 1);
    chk("len0_wr_count", wlog_a.size(), 0);
    run_cmd(1'b0, 300, 0, 0, 1, 1'b1, lat, nv);
    chk("len0_rd_latency", lat, 1);

    run_cmd(1'b1, 40, 5, 0, 0, 1'b0, lat, nv);
    chk("busy_start_count", wlog_a.size(), 5);
    if (wlog_a.size() > 0) chk("busy_start_base", wlog_a[0], 40);

    @(posedge clk_i); #1;
    start_i = 1'b1; mode_i = 1'b0; base_addr_i = '0; len_i = (AW + 1)'(8); out_ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_first_req", mem_req_o, 1'b1);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk_reset_outputs("midrst");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      out_ready_i = 1'b1;
      @(negedge clk_i);
      chk("midrst_no_done", done_o, 1'b0);
      chk("midrst_fifo_empty", out_valid_o, 1'b0);
    end

    for (int k = 0; k < 40; k++)
      run_cmd(1'($urandom), $urandom_range(0, N - 1), $urandom_range(0, 40),
              $urandom_range(0, 1), $urandom_range(0, 2), 1'b0, lat, nv);
    run_cmd(1'b1, $urandom_range(0, N - 1), 1024, 0, 0, 1'b0, lat, nv);
    chk("full_wr_count", wlog_a.size(), 1024);
    run_cmd(1'b0, $urandom_range(0, N - 1), 1024, 0, 0, 1'b0, lat, nv);
    chk("full_rd_count", rlog.size(), 1024);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cgra_sram_streamer.md
CGRA_SRAM_STREAMER -- requirements
Module: cgra_sram_streamer

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 1024, giving the SRAM depth in words.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data width; this revision supports only 32.
REQ-003 The block SHALL derive localparam AddrWidth as $clog2(NUM_WORDS) when NUM_WORDS>1, else 1; this value SHALL NOT be overridden.
REQ-004 The block SHALL use one clock, clk_i, and a synchronous active-low reset, rst_ni.
REQ-005 The block SHALL have these ports:
  - clk_i  in  1  clock
  - rst_ni  in  1  synchronous active-low reset
  - start_i  in  1  command strobe
  - mode_i  in  1  0 = read burst, 1 = write burst
  - base_addr_i  in  AddrWidth  first word address
  - len_i  in  AddrWidth+1  burst length in words
  - busy_o  out  1  command in progress
  - done_o  out  1  single-cycle completion pulse
  - in_valid_i  in  1  write-stream valid
  - in_ready_o  out  1  write-stream ready
  - in_data_i  in  32  write-stream data
  - in_be_i  in  4  write-stream byte enables
  - out_valid_o  out  1  read-stream valid
  - out_ready_i  in  1  read-stream ready
  - out_data_o  out  32  read-stream data
  - mem_req_o  out  1  SRAM request
  - mem_we_o  out  1  SRAM write enable
  - mem_addr_o  out  AddrWidth  SRAM address
  - mem_wdata_o  out  32  SRAM write data
  - mem_be_o  out  4  SRAM byte enables
  - mem_rdata_i  in  32  SRAM read data, valid one cycle after a read request

Function
REQ-006 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-007 In IDLE, start_i=1 SHALL latch base_addr_i, len_i and mode_i, then go to:
  - DONE when len_i=0, with no SRAM access;
  - READ when mode_i=0;
  - WRITE when mode_i=1.
REQ-008 start_i SHALL be ignored in every state other than IDLE.
REQ-009 busy_o SHALL be 1 in READ, WRITE and DONE, and 0 in IDLE.
REQ-010 done_o SHALL be 1 exactly in the DONE cycle; DONE SHALL always return to IDLE on the next cycle.
REQ-011 The SRAM address SHALL advance by one after each issued request and wrap from NUM_WORDS-1 to 0.
REQ-012 WRITE SHALL drive in_ready_o=1 for the whole state.
REQ-013 In WRITE, each cycle with in_valid_i=1 SHALL issue one SRAM write in that same cycle:
  - mem_req_o=1, mem_we_o=1;
  - mem_wdata_o=in_data_i, mem_be_o=in_be_i;
  - mem_addr_o = current address.
REQ-014 WRITE SHALL go to DONE in the cycle after the len-th write is issued.
REQ-015 READ SHALL issue SRAM reads with mem_req_o=1, mem_we_o=0 and mem_be_o=4'hF.
REQ-016 Read data SHALL be captured from mem_rdata_i on the cycle after its request and pushed into a 2-entry output FIFO.
REQ-017 A read SHALL be issued only when both conditions hold:
  - words issued < len;
  - FIFO count plus outstanding requests minus pops in this cycle is below 2.
REQ-018 Under REQ-017 the FIFO SHALL never overflow.
REQ-019 With out_ready_i held at 1, READ SHALL sustain one word per cycle.
REQ-020 The FIFO SHALL drive out_valid_o=1 whenever it is non-empty, with out_data_o set to its head word.
REQ-021 The FIFO SHALL pop on out_valid_o & out_ready_i.
REQ-022 out_valid_o and out_data_o SHALL hold stable while out_ready_i=0.
REQ-023 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-024 READ SHALL go to DONE in the cycle after the len-th word is popped.
REQ-025 Read data SHALL appear in ascending address order, including across the address wrap.
REQ-026 Outside active issue, mem_req_o and mem_we_o SHALL be 0.
REQ-027 in_ready_o SHALL be 0 outside WRITE.
REQ-028 mem_addr_o, mem_wdata_o and mem_be_o MAY be any value when mem_req_o=0.
REQ-029 len_i up to 2^AddrWidth SHALL be accepted; lengths above NUM_WORDS SHALL re-access wrapped addresses.

Reset
REQ-030 With rst_ni=0 at a clock edge, the next state SHALL be:
  - FSM in IDLE;
  - FIFO empty, outstanding-read flag cleared;
  - counters and address = 0;
  - busy_o, done_o, out_valid_o, in_ready_o, mem_req_o, mem_we_o = 0;
  - out_data_o, mem_wdata_o = 0, mem_addr_o = 0, mem_be_o = 0.
REQ-031 Reset in the middle of a burst SHALL abort it: no done_o pulse, and read data returning in the following cycle is discarded.

Verification
REQ-032 Write burst: base=5, len=3, in_valid_i held at 1, data A,B,C -> SRAM writes at addresses 5,6,7 on three consecutive cycles, then done_o on the next cycle.
REQ-033 Read burst with ready held: base=0, len=4, out_ready_i=1 -> out_valid_o high on four consecutive cycles with words 0..3, then done_o one cycle after the last pop.
REQ-034 Read backpressure: len=6, out_ready_i toggled 1/0 -> no data lost or duplicated, at most 2 words buffered, out_data_o stable while ready is low.
REQ-035 Wrap: NUM_WORDS=1024, base=1022, len=4, write burst -> addresses 1022, 1023, 0, 1.
REQ-036 len_i=0 -> no mem_req_o, done_o one cycle after start_i; start_i pulsed while busy -> ignored.
REQ-037 Reset mid-read, issued in the cycle after a request -> all outputs at reset values, FIFO empty, no done_o pulse.
